// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared opcode/state/flag types for the pipelined ALU.
// Optional macro ALU_PIPE_SHIFT_EN turns opcode 001 into a logical shift left.
package alu_pipe_pkg;

   // Opcode map presented on cntrl
   typedef enum logic [2:0] {
      OP_PASSB = 3'b000,
      OP_SHL   = 3'b001,  // reserved unless the shifter is built in
      OP_ADD   = 3'b010,
      OP_SUB   = 3'b011,
      OP_AND   = 3'b100,
      OP_OR    = 3'b101,
      OP_XOR   = 3'b110,
      OP_MUL   = 3'b111
   } alu_op_e;

   // Control FSM states
   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_MUL_BUSY = 1'b1
   } alu_state_e;

   // Architectural NZCV flags
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } alu_flags_t;

`ifdef ALU_PIPE_SHIFT_EN
   localparam bit SHIFT_EN = 1'b1;
`else
   localparam bit SHIFT_EN = 1'b0;
`endif

   // A reserved opcode may never touch the flag register
   function automatic logic op_writes_flags(alu_op_e op);
      return (op != OP_SHL) || SHIFT_EN;
   endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: input/output valid-ready handshake plus flag outputs of alu_pipe.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; the sender holds its payload stable while valid && !ready.
// state is a debug view of the control FSM.
interface alu_pipe_if #(parameter int WIDTH = 64);
   import alu_pipe_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       cntrl;
   logic             set_flags;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             negative;
   logic             zero;
   logic             overflow;
   logic             carry_out_flag;
   alu_state_e       state;

   modport slave (
      input  in_valid, A, B, cntrl, set_flags, out_ready,
      output in_ready, out_valid, result, negative, zero, overflow,
             carry_out_flag, state
   );

   modport master (
      output in_valid, A, B, cntrl, set_flags, out_ready,
      input  in_ready, out_valid, result, negative, zero, overflow,
             carry_out_flag, state
   );

endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, low WIDTH bits of a*b unsigned.
// start loads operands; WIDTH step cycles follow; done is high for one cycle
// after the last step while product holds the final value.
module alu_mul_iter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] count;
   logic             busy_q;

   // Load on start, then one add-and-shift step per cycle until count hits 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
         busy_q <= 1'b0;
      end else if (start) begin
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
         count  <= CNT_W'(WIDTH);
         busy_q <= 1'b1;
      end else if (busy_q) begin
         if (count != '0) begin
            if (mplier[0]) begin
               acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CNT_W'(1);
         end else begin
            busy_q <= 1'b0;
         end
      end
   end

   assign busy    = busy_q;
   assign done    = busy_q && (count == '0);
   assign product = acc;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready in/out, NZCV flag register and
// an iterative multiply. Define ALU_PIPE_SHIFT_EN to build opcode 001 as a
// logical shift left; otherwise 001 is reserved (result 0, flags untouched).
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic       clk,
   input  logic       reset,
   alu_pipe_if.slave  bus
);

`ifdef ALU_PIPE_SHIFT_EN
   localparam int SHAMT_W = $clog2(WIDTH);
`endif

   alu_state_e       state;
   alu_state_e       state_next;
   logic             out_valid_q;
   logic [WIDTH-1:0] result_q;
   alu_flags_t       flags_q;
   logic             sf_q;

   logic             in_ready;
   logic             accept;
   alu_op_e          op;

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum_ext;
   logic             c_into_msb;
   logic [WIDTH-1:0] sc_res;
   logic             sc_c;
   logic             sc_v;
`ifdef ALU_PIPE_SHIFT_EN
   logic [WIDTH:0]   shl_ext;
`endif

   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   logic             load_out;
   logic [WIDTH-1:0] load_val;
   logic             load_c;
   logic             load_v;
   logic             write_flags;

   // Accept only when idle and the output buffer is free or draining now
   assign in_ready = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;
   assign op       = alu_op_e'(bus.cntrl);

   // Single-cycle datapath: SUB reuses the adder as A + ~B + 1
   always_comb begin
      b_eff      = (op == OP_SUB) ? ~bus.B : bus.B;
      sum_ext    = {1'b0, bus.A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == OP_SUB)};
      c_into_msb = sum_ext[WIDTH-1] ^ bus.A[WIDTH-1] ^ b_eff[WIDTH-1];
`ifdef ALU_PIPE_SHIFT_EN
      shl_ext    = {1'b0, bus.A} << bus.B[SHAMT_W-1:0];
`endif
      sc_res     = '0;
      sc_c       = 1'b0;
      sc_v       = 1'b0;
      case (op)
         OP_PASSB: sc_res = bus.B;
         OP_ADD, OP_SUB: begin
            sc_res = sum_ext[WIDTH-1:0];
            sc_c   = sum_ext[WIDTH];
            sc_v   = c_into_msb ^ sum_ext[WIDTH];
         end
         OP_AND:   sc_res = bus.A & bus.B;
         OP_OR:    sc_res = bus.A | bus.B;
         OP_XOR:   sc_res = bus.A ^ bus.B;
`ifdef ALU_PIPE_SHIFT_EN
         // Bit WIDTH of the extended shift is the last bit pushed out
         OP_SHL: begin
            sc_res = shl_ext[WIDTH-1:0];
            sc_c   = shl_ext[WIDTH];
         end
`endif
         default:  sc_res = '0;
      endcase
   end

   // FSM next state and output-buffer / flag load decisions
   always_comb begin
      state_next  = state;
      mul_start   = 1'b0;
      load_out    = 1'b0;
      load_val    = sc_res;
      load_c      = sc_c;
      load_v      = sc_v;
      write_flags = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (op == OP_MUL) begin
                  mul_start  = 1'b1;
                  state_next = ST_MUL_BUSY;
               end else begin
                  load_out    = 1'b1;
                  write_flags = bus.set_flags && op_writes_flags(op);
               end
            end
         end
         ST_MUL_BUSY: begin
            if (mul_done) begin
               load_out    = 1'b1;
               load_val    = mul_product;
               load_c      = 1'b0;
               load_v      = 1'b0;
               write_flags = sf_q;
               state_next  = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Single-entry output buffer: load on completion, else drain on out_ready
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else if (load_out) begin
         out_valid_q <= 1'b1;
         result_q    <= load_val;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   // NZCV register, written on the output-buffer load edge when requested
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q <= '0;
      end else if (load_out && write_flags) begin
         flags_q.n <= load_val[WIDTH-1];
         flags_q.z <= (load_val == '0);
         flags_q.c <= load_c;
         flags_q.v <= load_v;
      end
   end

   // Keep the multiply's set_flags request until it completes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sf_q <= 1'b0;
      end else if (mul_start) begin
         sf_q <= bus.set_flags;
      end
   end

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .a       (bus.A),
      .b       (bus.B),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   assign bus.in_ready       = in_ready;
   assign bus.out_valid      = out_valid_q;
   assign bus.result         = result_q;
   assign bus.negative       = flags_q.n;
   assign bus.zero           = flags_q.z;
   assign bus.carry_out_flag = flags_q.c;
   assign bus.overflow       = flags_q.v;
   assign bus.state          = state;

   // mul_busy mirrors the FSM's MUL_BUSY state; kept for debug probing
   logic unused_ok;
   assign unused_ok = mul_busy;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed tests of alu_pipe at WIDTH=64 and WIDTH=8.
module tb_alu_pipe;
   import alu_pipe_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   alu_pipe_if #(.WIDTH(64)) bus64 ();
   alu_pipe_if #(.WIDTH(8))  bus8 ();

   alu_pipe #(.WIDTH(64)) dut64 (.clk(clk), .reset(reset), .bus(bus64.slave));
   alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));

   // Advance to 1 ns after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus64.in_valid = 1'b0; bus64.out_ready = 1'b1; bus64.A = '0; bus64.B = '0;
      bus64.cntrl = 3'b000; bus64.set_flags = 1'b0;
      bus8.in_valid = 1'b0; bus8.out_ready = 1'b1; bus8.A = '0; bus8.B = '0;
      bus8.cntrl = 3'b000; bus8.set_flags = 1'b0;
      repeat (3) tick();
      checks++; if (bus64.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus64.out_valid); end
      checks++; if (bus64.result !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus64.result); end
      checks++; if ({bus64.negative, bus64.zero, bus64.carry_out_flag, bus64.overflow} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {bus64.negative, bus64.zero, bus64.carry_out_flag, bus64.overflow}); end
      reset = 1'b0;
      tick();
      checks++; if (bus64.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready64 got=%0b exp=1", bus64.in_ready); end
      checks++; if (bus8.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready8 got=%0b exp=1", bus8.in_ready); end
      checks++; if (bus64.state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", bus64.state, ST_IDLE); end
   endtask

   task automatic test_add_flags();
      bus64.A = 64'h7FFF_FFFF_FFFF_FFFF; bus64.B = 64'd1; bus64.cntrl = 3'b010;
      bus64.set_flags = 1'b1; bus64.in_valid = 1'b1;
      checks++; if (bus64.in_ready !== 1'b1) begin failures++; $display("FAIL add_in_ready got=%0b exp=1", bus64.in_ready); end
      tick();
      bus64.in_valid = 1'b0;
      checks++; if (bus64.out_valid !== 1'b1) begin failures++; $display("FAIL add_out_valid got=%0b exp=1", bus64.out_valid); end
      checks++; if (bus64.result !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL add_result got=%h exp=8000000000000000", bus64.result); end
      checks++; if ({bus64.negative, bus64.zero, bus64.carry_out_flag, bus64.overflow} !== 4'b1001) begin failures++; $display("FAIL add_flags got=%b exp=1001", {bus64.negative, bus64.zero, bus64.carry_out_flag, bus64.overflow}); end
   endtask

   task automatic test_sub_flags();
      bus64.A = 64'd5; bus64.B = 64'd5; bus64.cntrl = 3'b011;
      bus64.set_flags = 1'b0; bus64.in_valid = 1'b1;
      tick();
      bus64.in_valid = 1'b0;
      checks++; if (bus64.result !== 64'd0) begin failures++; $display("FAIL sub_nf_result got=%h exp=0", bus64.result); end
      checks++; if ({bus64.negative, bus64.zero, bus64.carry_out_flag, bus64.overflow} !== 4'b1001) begin failures++; $display("FAIL sub_nf_flags got=%b exp=1001", {bus64.negative, bus64.zero, bus64.carry_out_flag, bus64.overflow}); end
      bus64.set_flags = 1'b1; bus64.in_valid = 1'b1;
      tick();
      bus64.in_valid = 1'b0;
      checks++; if (bus64.result !== 64'd0) begin failures++; $display("FAIL sub_f_result got=%h exp=0", bus64.result); end
      checks++; if ({bus64.negative, bus64.zero, bus64.carry_out_flag, bus64.overflow} !== 4'b0110) begin failures++; $display("FAIL sub_f_flags got=%b exp=0110", {bus64.negative, bus64.zero, bus64.carry_out_flag, bus64.overflow}); end
      bus64.set_flags = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [2:0]  ops [4];
      logic [63:0] exp [4];
      ops[0] = 3'b000; exp[0] = 64'h0FF0;
      ops[1] = 3'b100; exp[1] = 64'h00F0;
      ops[2] = 3'b101; exp[2] = 64'hFFF0;
      ops[3] = 3'b110; exp[3] = 64'hFF00;
      bus64.A = 64'hF0F0; bus64.B = 64'h0FF0; bus64.set_flags = 1'b0; bus64.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus64.cntrl = ops[i]; bus64.in_valid = 1'b1;
         checks++; if (bus64.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready[%0d] got=%0b exp=1", i, bus64.in_ready); end
         tick();
         checks++; if (bus64.out_valid !== 1'b1 || bus64.result !== exp[i]) begin failures++; $display("FAIL b2b_result[%0d] valid=%0b got=%h exp=%h", i, bus64.out_valid, bus64.result, exp[i]); end
      end
      bus64.in_valid = 1'b0;
      tick();
      checks++; if (bus64.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", bus64.out_valid); end
   endtask

   task automatic test_mul();
      int busy_cycles;
      int lat;
      bus8.A = 8'd13; bus8.B = 8'd11; bus8.cntrl = 3'b111; bus8.set_flags = 1'b1;
      bus8.out_ready = 1'b1; bus8.in_valid = 1'b1;
      checks++; if (bus8.in_ready !== 1'b1) begin failures++; $display("FAIL mul_in_ready_pre got=%0b exp=1", bus8.in_ready); end
      tick();
      // Operand changes while busy must not disturb the product
      bus8.in_valid = 1'b0; bus8.A = 8'hFF; bus8.B = 8'hFF; bus8.cntrl = 3'b010; bus8.set_flags = 1'b0;
      busy_cycles = 0;
      lat = 0;
      while (!bus8.out_valid && lat < 20) begin
         if (!bus8.in_ready) busy_cycles++;
         tick();
         lat++;
      end
      checks++; if (lat !== 9) begin failures++; $display("FAIL mul_latency got=%0d exp=9", lat); end
      checks++; if (busy_cycles !== 9) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=9", busy_cycles); end
      checks++; if (bus8.result !== 8'h8F) begin failures++; $display("FAIL mul_result got=%h exp=8f", bus8.result); end
      checks++; if ({bus8.negative, bus8.zero, bus8.carry_out_flag, bus8.overflow} !== 4'b1000) begin failures++; $display("FAIL mul_flags got=%b exp=1000", {bus8.negative, bus8.zero, bus8.carry_out_flag, bus8.overflow}); end
      tick();
      checks++; if (bus8.out_valid !== 1'b0) begin failures++; $display("FAIL mul_drain got=%0b exp=0", bus8.out_valid); end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_q[$];
      logic [7:0] exp_v;
      int         received;
      int         last_i;
      exp_q = {8'h30, 8'hFC, 8'hCC};
      received = 0;
      last_i = -1;
      bus8.A = 8'hF0; bus8.B = 8'h3C; bus8.set_flags = 1'b0; bus8.out_ready = 1'b0;
      bus8.cntrl = 3'b100; bus8.in_valid = 1'b1;
      checks++; if (bus8.in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_first got=%0b exp=1", bus8.in_ready); end
      tick();
      bus8.cntrl = 3'b101;
      for (int s = 0; s < 3; s++) begin
         checks++; if (bus8.out_valid !== 1'b1 || bus8.result !== 8'h30) begin failures++; $display("FAIL bp_hold[%0d] valid=%0b got=%h exp=30", s, bus8.out_valid, bus8.result); end
         checks++; if (bus8.in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready[%0d] got=%0b exp=0", s, bus8.in_ready); end
         tick();
      end
      bus8.out_ready = 1'b1;
      #1;
      checks++; if (bus8.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b exp=1", bus8.in_ready); end
      for (int i = 0; i < 8; i++) begin
         if (bus8.out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL bp_extra got=%h exp=none", bus8.result);
            end else begin
               exp_v = exp_q.pop_front();
               if (bus8.result !== exp_v) begin failures++; $display("FAIL bp_stream[%0d] got=%h exp=%h", received, bus8.result, exp_v); end
            end
            received++;
            last_i = i;
         end
         if (received == 2) bus8.cntrl = 3'b110;
         if (received >= 3) bus8.in_valid = 1'b0;
         tick();
      end
      bus8.in_valid = 1'b0;
      checks++; if (received !== 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", received); end
      checks++; if (last_i !== 2) begin failures++; $display("FAIL bp_consecutive last_cycle got=%0d exp=2", last_i); end
      checks++; if (bus8.out_valid !== 1'b0) begin failures++; $display("FAIL bp_final_valid got=%0b exp=0", bus8.out_valid); end
   endtask

   task automatic test_opcode_001();
      logic [7:0] exp_res;
      logic [3:0] exp_flags;
`ifdef ALU_PIPE_SHIFT_EN
      exp_res = 8'h02; exp_flags = 4'b0010;
`else
      exp_res = 8'h00; exp_flags = 4'b1000;
`endif
      bus8.A = 8'h81; bus8.B = 8'h01; bus8.cntrl = 3'b001; bus8.set_flags = 1'b1;
      bus8.out_ready = 1'b1; bus8.in_valid = 1'b1;
      tick();
      bus8.in_valid = 1'b0; bus8.set_flags = 1'b0;
      checks++; if (bus8.out_valid !== 1'b1) begin failures++; $display("FAIL op001_valid got=%0b exp=1", bus8.out_valid); end
      checks++; if (bus8.result !== exp_res) begin failures++; $display("FAIL op001_result got=%h exp=%h", bus8.result, exp_res); end
      checks++; if ({bus8.negative, bus8.zero, bus8.carry_out_flag, bus8.overflow} !== exp_flags) begin failures++; $display("FAIL op001_flags got=%b exp=%b", {bus8.negative, bus8.zero, bus8.carry_out_flag, bus8.overflow}, exp_flags); end
      tick();
   endtask

   task automatic test_reset_mid_mul();
      int stale;
      bus64.A = 64'd2; bus64.B = 64'd3; bus64.cntrl = 3'b010; bus64.set_flags = 1'b0;
      bus64.out_ready = 1'b1; bus64.in_valid = 1'b1;
      tick();
      bus64.in_valid = 1'b0;
      tick();
      bus64.A = 64'd3; bus64.B = 64'd5; bus64.cntrl = 3'b111; bus64.set_flags = 1'b1; bus64.in_valid = 1'b1;
      tick();
      bus64.in_valid = 1'b0;
      repeat (9) tick();
      checks++; if (bus64.state !== ST_MUL_BUSY) begin failures++; $display("FAIL rmm_busy got=%0d exp=%0d", bus64.state, ST_MUL_BUSY); end
      checks++; if (bus64.result !== 64'd5) begin failures++; $display("FAIL rmm_result_held got=%h exp=5", bus64.result); end
      reset = 1'b1;
      #1;
      checks++; if (bus64.out_valid !== 1'b0) begin failures++; $display("FAIL rmm_out_valid got=%0b exp=0", bus64.out_valid); end
      checks++; if (bus64.result !== 64'd0) begin failures++; $display("FAIL rmm_result got=%h exp=0", bus64.result); end
      checks++; if ({bus64.negative, bus64.zero, bus64.carry_out_flag, bus64.overflow} !== 4'b0000) begin failures++; $display("FAIL rmm_flags got=%b exp=0000", {bus64.negative, bus64.zero, bus64.carry_out_flag, bus64.overflow}); end
      checks++; if (bus64.state !== ST_IDLE) begin failures++; $display("FAIL rmm_state got=%0d exp=%0d", bus64.state, ST_IDLE); end
      repeat (2) tick();
      reset = 1'b0;
      #1;
      checks++; if (bus64.in_ready !== 1'b1) begin failures++; $display("FAIL rmm_in_ready got=%0b exp=1", bus64.in_ready); end
      stale = 0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (bus64.out_valid) stale++;
      end
      checks++; if (stale !== 0) begin failures++; $display("FAIL rmm_stale_completion got=%0d exp=0", stale); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_add_flags();
      test_sub_flags();
      test_back_to_back();
      test_mul();
      test_backpressure();
      test_opcode_001();
      test_reset_mid_mul();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the combinational datapath ALU.
- Accepts one operation per handshake on a valid/ready input and returns a registered result on a valid/ready output.
- Holds an architectural NZCV flag register that is written only when the op requests it, as ADDS/SUBS do in the CPU execute stage.
- Adds an iterative multi-cycle multiply (shift-add FSM) alongside the single-cycle ops.

Parameters:
- WIDTH, 64, datapath width in bits; legal range 8..64.
- SHAMT_W, $clog2(WIDTH), derived shift-amount width; not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation presented
- in_ready  output  1  block can accept an operation
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- cntrl  input  3  opcode
- set_flags  input  1  write the NZCV register when this op completes
- out_valid  output  1  result held
- out_ready  input  1  consumer takes result
- result  output  WIDTH  registered result
- negative, zero, overflow, carry_out_flag  output  1 each  architectural flag register

Behaviour:
- Opcode map:
  - 000 result = B
  - 001 reserved
  - 010 A+B
  - 011 A−B, computed as A+~B+1
  - 100 AND
  - 101 OR
  - 110 XOR
  - 111 MUL, low WIDTH bits of A*B, unsigned
- Accept: an op is accepted on a clk edge where in_valid && in_ready.
- FSM states: IDLE, MUL_BUSY. A single output buffer holds result and out_valid.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Same-cycle drain plus accept is allowed.
- Single-cycle ops:
  - Result is registered on the accept edge; out_valid=1 the next cycle (latency 1).
  - Back-to-back throughput is 1 op/cycle while out_ready=1.
- MUL:
  - The accept edge loads the multiplicand/multiplier and sets count=WIDTH, then IDLE→MUL_BUSY.
  - Each cycle adds the shifted multiplicand to the accumulator if the multiplier LSB is 1, then decrements count.
  - When count reaches 0, the output buffer is loaded, out_valid=1 and the FSM returns to IDLE.
  - Latency is WIDTH+1 cycles from accept to out_valid. in_ready=0 throughout.
- Output hold: while out_valid && !out_ready, result is stable. out_valid drops on the edge where out_ready=1 with no new completion.
- Flags: written on the same edge the output buffer loads, and only if the captured set_flags=1.
  - N = result[WIDTH-1]; Z = (result==0).
  - ADD/SUB:
    - C = carry out of bit WIDTH-1. For SUB, C=1 means no borrow.
    - V = carry into MSB XOR carry out of MSB.
  - B-pass/logical/MUL: C=0, V=0.
  - With set_flags=0, all four flags keep their values.
- Reserved opcode (macro off): result=0, out_valid asserted after 1 cycle, flags never written regardless of set_flags.
- Reset: asserting reset at any time, including mid-MUL, forces the following:
  - state=IDLE
  - out_valid=0
  - result=0
  - all flags=0
  - in_ready=1 once reset deasserts
- Inputs are sampled only on the accept edge. A, B and cntrl changing during MUL_BUSY have no effect.

Optional Feature:
- Macro: ALU_PIPE_SHIFT_EN.
- Defined: opcode 001 = logical shift left, A << B[SHAMT_W-1:0], single-cycle.
  - C = last bit shifted out, or 0 when the shift amount is 0.
  - V = 0; N and Z as usual.
- Undefined: opcode 001 behaves as reserved, with no shifter hardware instantiated.

Decomposition:
- Package alu_pipe_pkg holds:
  - alu_op_e, a 3-bit enum of the opcodes above
  - alu_state_e, the IDLE/MUL_BUSY enum
  - flag struct {n,z,c,v}
- Sub-module alu_mul_iter, parametrised by WIDTH:
  - start/busy/done interface
  - contains the shift-add datapath and down-counter
  - alu_pipe owns the handshake and flags

Test Plan:
- Reset mid-MUL:
  - WIDTH=64, MUL A=3, B=5; assert reset at cycle 10.
  - Required: out_valid=0, result=0, flags=0000, in_ready=1 after release, no stale completion.
- Add with flags, WIDTH=64:
  - A=64'h7FFF_FFFF_FFFF_FFFF, B=1, cntrl=010, set_flags=1.
  - Required: result=64'h8000_0000_0000_0000, N=1 Z=0 C=0 V=1, out_valid one cycle after accept.
- Subtract, flags untouched:
  - A=5, B=5, cntrl=011, set_flags=0, after the add above.
  - Required: result=0, flags still N=1 Z=0 C=0 V=1.
  - Repeat with set_flags=1; required: Z=1 C=1 N=0 V=0.
- Multiply, WIDTH=8:
  - A=8'd13, B=8'd11, cntrl=111.
  - Required: in_ready=0 for 9 cycles, result=8'h8F (143 mod 256), out_valid on cycle 9.
- Backpressure:
  - Stream AND, OR, XOR (A=8'hF0, B=8'h3C) with out_ready=0 for 3 cycles, then 1.
  - Required: result holds 8'h30 while stalled, in_ready=0, then 8'h30, 8'hFC, 8'hCC on consecutive cycles with no loss or duplication.
- Opcode 001:
  - A=8'h81, B=1, set_flags=1.
  - Macro on: result=8'h02, C=1.
  - Macro off: result=0, flags unchanged.
